// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Pre-IF PC generator plus a single
//                IF slot, fetching over an SRAM-like req/addr_ok/data_ok port
//                with at most one outstanding request. Holds returned data
//                while decode stalls and discards wrong-path fetches after a
//                branch redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [33:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    localparam logic [31:0] c_PC_STEP = 32'd4;

    // EMPTY: nothing held; WAIT: address accepted, data pending;
    // READY: instruction parked in r_inst_buf; DROP: wrong-path data pending.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2,
        S_DROP  = 2'd3
    } slot_t;

    slot_t       r_slot;
    slot_t       w_slot_nxt;
    logic [31:0] r_pf_addr;
    logic [31:0] r_br_buf;
    logic        r_br_buf_valid;
    logic        r_pf_req_pend;
    logic        r_kill_pend;
    logic [31:0] r_inst_buf;
    logic [31:0] r_fs_pc;

    logic        w_br_cancel;
    logic        w_br_taken;
    logic        w_br_stall;
    logic [31:0] w_br_target;
    logic        w_slot_free;
    logic        w_req;
    logic        w_accept;
    logic        w_wrong_path;
    logic [31:0] w_pf_addr_nxt;
    logic [31:0] w_fs_inst;

    assign w_br_cancel = br_bus[33];
    assign w_br_taken  = br_bus[32];
    assign w_br_target = {br_bus[31:2], 2'b00};
    // A taken branch not yet resolved into a redirect only blocks new fetches.
    assign w_br_stall  = w_br_taken & ~w_br_cancel;

    // The slot can take a new address if it will be vacated this cycle.
    assign w_slot_free = (r_slot == S_EMPTY)
                       | ((r_slot == S_READY) & ds_allowin)
                       | ((r_slot == S_WAIT) & inst_sram_data_ok & ds_allowin);

    // A raised request stays up until accepted, regardless of stalls.
    assign w_req        = ~reset & (r_pf_req_pend | (w_slot_free & ~w_br_stall));
    assign w_accept     = w_req & inst_sram_addr_ok;
    assign w_wrong_path = w_br_cancel | r_kill_pend;

    assign inst_sram_req   = w_req;
    assign inst_sram_addr  = r_pf_addr;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'd0;

    assign w_fs_inst      = (r_slot == S_READY) ? r_inst_buf : inst_sram_rdata;
    assign fs_to_ds_valid = ~reset & ~w_br_cancel
                          & (((r_slot == S_WAIT) & inst_sram_data_ok) | (r_slot == S_READY));
    assign fs_to_ds_bus   = {w_fs_inst, r_fs_pc};

    // Next fetch address: a buffered redirect wins, then a live redirect,
    // otherwise sequential. An idle port redirects immediately.
    always_comb begin
        w_pf_addr_nxt = r_pf_addr;
        if (w_accept) begin
            if (r_br_buf_valid) begin
                w_pf_addr_nxt = r_br_buf;
            end else if (w_br_cancel) begin
                w_pf_addr_nxt = w_br_target;
            end else begin
                w_pf_addr_nxt = r_pf_addr + c_PC_STEP;
            end
        end else if (w_br_cancel && !w_req) begin
            w_pf_addr_nxt = w_br_target;
        end
    end

    // Pre-IF state: fetch address, pending request and buffered redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pf_addr      <= RESET_PC;
            r_pf_req_pend  <= 1'b0;
            r_br_buf       <= 32'd0;
            r_br_buf_valid <= 1'b0;
            r_kill_pend    <= 1'b0;
        end else begin
            r_pf_addr     <= w_pf_addr_nxt;
            r_pf_req_pend <= w_req & ~inst_sram_addr_ok;
            if (w_accept) begin
                r_br_buf_valid <= 1'b0;
                r_kill_pend    <= 1'b0;
            end else if (w_br_cancel && w_req) begin
                // The held address is now wrong-path; remember where to go next.
                r_br_buf       <= w_br_target;
                r_br_buf_valid <= 1'b1;
                r_kill_pend    <= 1'b1;
            end
        end
    end

    // IF slot next state.
    always_comb begin
        w_slot_nxt = r_slot;
        case (r_slot)
            S_EMPTY: begin
                if (w_accept) begin
                    w_slot_nxt = w_wrong_path ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    if (w_accept) begin
                        w_slot_nxt = w_wrong_path ? S_DROP : S_WAIT;
                    end else if (w_br_cancel || ds_allowin) begin
                        w_slot_nxt = S_EMPTY;
                    end else begin
                        w_slot_nxt = S_READY;
                    end
                end else if (w_br_cancel) begin
                    w_slot_nxt = S_DROP;
                end
            end
            S_READY: begin
                if (w_accept) begin
                    w_slot_nxt = w_wrong_path ? S_DROP : S_WAIT;
                end else if (w_br_cancel || ds_allowin) begin
                    w_slot_nxt = S_EMPTY;
                end
            end
            S_DROP: begin
                if (inst_sram_data_ok) begin
                    w_slot_nxt = S_EMPTY;
                end
            end
            default: w_slot_nxt = S_EMPTY;
        endcase
    end

    // Slot state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot <= S_EMPTY;
        end else begin
            r_slot <= w_slot_nxt;
        end
    end

    // Slot payload: PC captured at address accept, instruction parked on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fs_pc    <= 32'd0;
            r_inst_buf <= 32'd0;
        end else begin
            if (w_accept) begin
                r_fs_pc <= r_pf_addr;
            end
            if ((r_slot == S_WAIT) && inst_sram_data_ok && (w_slot_nxt == S_READY)) begin
                r_inst_buf <= inst_sram_rdata;
            end
        end
    end

endmodule
`default_nettype wire
